// File: rtl/educ8_pkg.sv
// Shared constants for the EDUC-8 major-state sequencer: major-state
// indices and one-hot codes, opcode values, default timing parameters
// and the controller state type.
package educ8_pkg;

  localparam int TP_W_DEF   = 3;
  localparam int MEM_TP_DEF = 3;

  localparam int MS_FETCH = 0;
  localparam int MS_DEFER = 1;
  localparam int MS_EXEC  = 2;
  localparam int MS_INT   = 3;

  localparam logic [3:0] MAJOR_IDLE  = 4'b0000;
  localparam logic [3:0] MAJOR_FETCH = 4'(1 << MS_FETCH);
  localparam logic [3:0] MAJOR_DEFER = 4'(1 << MS_DEFER);
  localparam logic [3:0] MAJOR_EXEC  = 4'(1 << MS_EXEC);
  localparam logic [3:0] MAJOR_INT   = 4'(1 << MS_INT);

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_TAD = 3'd1;
  localparam logic [2:0] OP_ISZ = 3'd2;
  localparam logic [2:0] OP_DCA = 3'd3;
  localparam logic [2:0] OP_JMS = 3'd4;
  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DEFER,
    ST_EXEC,
    ST_INT
  } state_e;

  // One-hot front-panel major-state code for a controller state.
  function automatic logic [3:0] major_onehot(state_e s);
    case (s)
      ST_FETCH: major_onehot = MAJOR_FETCH;
      ST_DEFER: major_onehot = MAJOR_DEFER;
      ST_EXEC:  major_onehot = MAJOR_EXEC;
      ST_INT:   major_onehot = MAJOR_INT;
      default:  major_onehot = MAJOR_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/educ8_tp_gen.sv
// Time-pulse generator: TP_W-bit pulse counter with synchronous clear,
// hold while the memory access at MEM_TP is pending, registered one-hot
// decode and a last-pulse flag for the parent FSM.
module educ8_tp_gen
  import educ8_pkg::*;
#(
  parameter int TP_W   = TP_W_DEF,
  parameter int MEM_TP = MEM_TP_DEF
) (
  input  logic                   clk,
  input  logic                   nclr,
  input  logic                   run_i,
  input  logic                   clr_i,
  input  logic                   mem_ready_i,
  output logic [(1<<TP_W)-1:0]   tp_o,
  output logic                   last_o,
  output logic                   adv_o
);

  localparam int N = 1 << TP_W;

  logic [TP_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]    tp_q, tp_d;
  logic            stall;

  // A MEM_TP outside the pulse range can never be reached, so it never stalls.
  assign stall  = (MEM_TP < N) && (cnt_q == TP_W'(MEM_TP)) && !mem_ready_i;
  assign adv_o  = !stall;
  assign last_o = run_i && (&cnt_q);
  assign tp_o   = tp_q;

  // Next count (natural wrap at N-1) and its one-hot decode; clear blanks tp.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (run_i && !stall) begin
      cnt_d = cnt_q + TP_W'(1);
    end
    tp_d = '0;
    if (!clr_i) begin
      tp_d[cnt_d] = 1'b1;
    end
  end

  // Counter and pulse register, so tp changes on the same edge as the count.
  always_ff @(posedge clk) begin
    if (!nclr) begin
      cnt_q <= '0;
      tp_q  <= '0;
    end else begin
      cnt_q <= cnt_d;
      tp_q  <= tp_d;
    end
  end

endmodule

// File: rtl/educ8_major_state_ctrl.sv
// EDUC-8 major-state controller: FETCH/DEFER/EXECUTE(/INTERRUPT) sequencing
// and run/stop/single-step handling at the instruction boundary.
// Optional interrupt entry is built when EDUC8_INTERRUPT_EN is defined.
module educ8_major_state_ctrl
  import educ8_pkg::*;
#(
  parameter int TP_W   = TP_W_DEF,
  parameter int MEM_TP = MEM_TP_DEF
) (
  input  logic       clk,
  input  logic       nclr,
  input  logic       start,
  input  logic       stop,
  input  logic       sstep,
  input  logic       hlt_req,
  input  logic [2:0] opcode,
  input  logic       ind,
  input  logic       mem_ready,
  input  logic       int_req,
  output logic [3:0] major,
  output logic [7:0] tp,
  output logic       running,
  output logic       instr_done,
  output logic       int_ack
);

  localparam int N = 1 << TP_W;
`ifdef EDUC8_INTERRUPT_EN
  localparam logic [3:0] MAJOR_MASK = 4'b1111;
`else
  localparam logic [3:0] MAJOR_MASK = 4'b0111;
`endif

  state_e       state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic         ind_q, ind_d;
  logic [3:0]   major_q;
  logic         running_q;
  logic         boundary;
  logic         end_pulse;
  logic         tp_last;
  logic         tp_adv;
  logic         tp_clr;
  logic [N-1:0] tp_n;

  assign end_pulse = tp_last && tp_adv;
  assign tp_clr    = (state_d == ST_IDLE);

  educ8_tp_gen #(
    .TP_W   (TP_W),
    .MEM_TP (MEM_TP)
  ) u_tp_gen (
    .clk         (clk),
    .nclr        (nclr),
    .run_i       (running_q),
    .clr_i       (tp_clr),
    .mem_ready_i (mem_ready),
    .tp_o        (tp_n),
    .last_o      (tp_last),
    .adv_o       (tp_adv)
  );

  // Map the N decoded pulses onto the fixed 8-bit tp port.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_tp
      if (gi < N) begin : g_used
        assign tp[gi] = tp_n[gi];
      end else begin : g_zero
        assign tp[gi] = 1'b0;
      end
    end
  endgenerate

`ifdef EDUC8_INTERRUPT_EN
  logic int_ack_q, int_ack_d;
  assign int_ack = int_ack_q;
`else
  logic unused_int_req;
  assign unused_int_req = int_req;
  assign int_ack        = 1'b0;
`endif

  // Next major state; FETCH decides with the live opcode, later states with the latched copy.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    ind_d    = ind_q;
    boundary = 1'b0;
`ifdef EDUC8_INTERRUPT_EN
    int_ack_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (end_pulse) begin
          op_d  = opcode;
          ind_d = ind;
          if (ind && (opcode <= OP_JMP))  state_d  = ST_DEFER;
          else if (opcode <= OP_JMS)      state_d  = ST_EXEC;
          else                            boundary = 1'b1;
        end
      end
      ST_DEFER: begin
        if (end_pulse) begin
          if (op_q <= OP_JMS) state_d  = ST_EXEC;
          else                boundary = 1'b1;
        end
      end
      ST_EXEC: begin
        if (end_pulse) boundary = 1'b1;
      end
`ifdef EDUC8_INTERRUPT_EN
      ST_INT: begin
        if (end_pulse) boundary = 1'b1;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (boundary) begin
      if (stop || sstep || hlt_req) begin
        state_d = ST_IDLE;
      end
`ifdef EDUC8_INTERRUPT_EN
      else if (int_req) begin
        state_d   = ST_INT;
        int_ack_d = 1'b1;
      end
`endif
      else begin
        state_d = ST_FETCH;
      end
    end
  end

  // The end-of-instruction strobe is the boundary decision itself, so it
  // cannot fire while a last-pulse memory stall is still holding the count.
  assign instr_done = boundary;
  assign major      = major_q;
  assign running    = running_q;

  // State register with registered one-hot major code and running flag.
  always_ff @(posedge clk) begin
    if (!nclr) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_AND;
      ind_q     <= 1'b0;
      major_q   <= MAJOR_IDLE;
      running_q <= 1'b0;
`ifdef EDUC8_INTERRUPT_EN
      int_ack_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ind_q     <= ind_d;
      major_q   <= major_onehot(state_d) & MAJOR_MASK;
      running_q <= (state_d != ST_IDLE);
`ifdef EDUC8_INTERRUPT_EN
      int_ack_q <= int_ack_d;
`endif
    end
  end

endmodule
